// File: rtl/bch3d_128_syn_chk.sv
// bch3d_128_syn_chk: syndrome checker for the 145-bit BCH3D codeword (128 data + 17 parity)
module bch3d_128_syn_chk #(
    parameter int          CHUNK    = 29,
    parameter logic [17:0] GEN_POLY = 18'h3B1A5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [0:144]  i_code,
    output logic          o_busy,
    output logic          o_valid,
    output logic [16:0]   o_syndrome,
    output logic          o_err,
    output logic [0:127]  o_data
);
    localparam int NCHUNK = 145 / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [16:0]   r_lfsr;
    logic [0:144]  r_sr;
    logic          r_valid;
    logic [16:0]   r_syndrome;
    logic          r_err;
    logic [0:127]  r_data;
    logic [16:0]   w_lfsr;
    logic [0:144]  w_rot;

    // Horner division: remainder = (remainder * x + b) mod g(x), one received bit at a time
    function automatic logic [16:0] fold(input logic [16:0] s, input logic [0:CHUNK-1] b);
        for (int i = 0; i < CHUNK; i++)
            s = s[16] ? ({s[15:0], b[i]} ^ GEN_POLY[16:0]) : {s[15:0], b[i]};
        return s;
    endfunction

    // Next remainder and rotated word; after NCHUNK rotations the word is back in capture order
    always_comb begin
        w_lfsr = fold(r_lfsr, r_sr[0:CHUNK-1]);
        w_rot  = (r_sr << CHUNK) | (r_sr >> (145 - CHUNK));
    end

    // IDLE/DONE sample enable, SHIFT folds CHUNK bits per edge and publishes on the last one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lfsr     <= '0;
            r_sr       <= '0;
            r_valid    <= 1'b0;
            r_syndrome <= '0;
            r_err      <= 1'b0;
            r_data     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == S_SHIFT) begin
                r_lfsr <= w_lfsr;
                r_sr   <= w_rot;
                r_cnt  <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_state    <= S_DONE;
                    r_valid    <= 1'b1;
                    r_syndrome <= w_lfsr;
                    r_err      <= |w_lfsr;
                    r_data     <= w_rot[0:127];
                end
            end else if (enable) begin
                r_sr    <= i_code;
                r_lfsr  <= '0;
                r_cnt   <= '0;
                r_state <= S_SHIFT;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    assign o_busy     = (r_state == S_SHIFT);
    assign o_valid    = r_valid;
    assign o_syndrome = r_syndrome;
    assign o_err      = r_err;
    assign o_data     = r_data;
endmodule

// File: tb/tb_bch3d_128_syn_chk.sv
// tb_bch3d_128_syn_chk: randomized checks of the syndrome checker at CHUNK = 29, 1 and 145
module tb_bch3d_128_syn_chk;
    localparam logic [17:0] GP = 18'h3B1A5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en[3];
    logic [0:144] code[3];
    logic         bsy[3], vld[3], err[3];
    logic [16:0]  syn[3];
    logic [0:127] dat[3];
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bch3d_128_syn_chk #(
            .CHUNK   (g == 0 ? 29 : (g == 1 ? 1 : 145)),
            .GEN_POLY(GP)
        ) u_dut (
            .clk       (clk),
            .reset_n   (rst_n),
            .enable    (en[g]),
            .i_code    (code[g]),
            .o_busy    (bsy[g]),
            .o_valid   (vld[g]),
            .o_syndrome(syn[g]),
            .o_err     (err[g]),
            .o_data    (dat[g])
        );
    end

    function automatic int nch(input int k);
        return k == 0 ? 5 : (k == 1 ? 145 : 1);
    endfunction

    // Reference: plain long division of the codeword polynomial by g(x)
    function automatic logic [16:0] ref_rem(input logic [0:144] c);
        logic [144:0] w;
        w = c;
        for (int j = 144; j >= 17; j--)
            if (w[j]) w ^= {127'd0, GP} << (j - 17);
        return w[16:0];
    endfunction

    function automatic logic [0:144] enc(input logic [127:0] d);
        logic [0:144] t;
        t = {d, 17'd0};
        return {d, ref_rem(t)};
    endfunction

    function automatic logic [127:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic send(input int k, input logic [0:144] c, output int lat);
        @(negedge clk); en[k] = 1'b1; code[k] = c;
        @(negedge clk); en[k] = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!vld[k] && lat < 400);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({bsy[k], vld[k], err[k], syn[k], dat[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset[%0d]: busy=%b valid=%b err=%b syn=%h data=%h, want all zero", k, bsy[k], vld[k], err[k], syn[k], dat[k]);
            end
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_word(input int k);
        int lat;
        send(k, '0, lat);
        n_chk++;
        if (lat !== nch(k)) begin n_fail++; $display("FAIL zero_latency[%0d]: got %0d want %0d", k, lat, nch(k)); end
        n_chk++;
        if (syn[k] !== 17'h0 || err[k] !== 1'b0 || dat[k] !== '0) begin
            n_fail++; $display("FAIL zero_result[%0d]: syn=%h err=%b data=%h want 0/0/0", k, syn[k], err[k], dat[k]);
        end
        @(posedge clk); #1;
        n_chk++;
        if (vld[k] !== 1'b0) begin n_fail++; $display("FAIL zero_pulse[%0d]: valid=%b want 0", k, vld[k]); end
    endtask

    task automatic test_bit_flip(input int k);
        logic [0:144] c, e;
        int lat;
        c = enc(rnd_data());
        e = c; e[144] = ~e[144];
        send(k, e, lat);
        n_chk++;
        if (syn[k] !== 17'h00001 || err[k] !== 1'b1 || dat[k] !== c[0:127]) begin
            n_fail++; $display("FAIL flip144[%0d]: syn=%h err=%b data=%h want 00001/1/%h", k, syn[k], err[k], dat[k], c[0:127]);
        end
        @(posedge clk); #1;
        n_chk++;
        if (vld[k] !== 1'b0 || syn[k] !== 17'h00001 || err[k] !== 1'b1) begin
            n_fail++; $display("FAIL hold[%0d]: valid=%b syn=%h err=%b want 0/00001/1", k, vld[k], syn[k], err[k]);
        end
        e = c; e[128] = ~e[128];
        send(k, e, lat);
        n_chk++;
        if (syn[k] !== 17'h10000 || err[k] !== 1'b1) begin
            n_fail++; $display("FAIL flip128[%0d]: syn=%h err=%b want 10000/1", k, syn[k], err[k]);
        end
    endtask

    task automatic test_random(input int k);
        logic [0:144] c;
        logic [16:0] exp_s;
        int lat;
        for (int n = 0; n < 5; n++) begin
            c = enc(rnd_data());
            for (int f = 0; f < n; f++) c[$urandom_range(144, 0)] ^= 1'b1;
            exp_s = ref_rem(c);
            send(k, c, lat);
            n_chk++;
            if (lat !== nch(k) || syn[k] !== exp_s || err[k] !== (exp_s != 0) || dat[k] !== c[0:127]) begin
                n_fail++;
                $display("FAIL random[%0d.%0d]: lat=%0d syn=%h err=%b data=%h want %0d/%h/%b/%h", k, n, lat, syn[k], err[k], dat[k], nch(k), exp_s, exp_s != 0, c[0:127]);
            end
        end
    endtask

    task automatic test_back_to_back(input int k);
        logic [127:0] d[3];
        logic [0:144] w[3];
        int lat;
        d[0] = 128'hb4705b94; d[1] = 128'hb35ae135; d[2] = 128'hf4631f09;
        for (int i = 0; i < 3; i++) w[i] = enc(d[i]);
        @(negedge clk); en[k] = 1'b1; code[k] = w[0];
        @(posedge clk); #1; code[k] = w[1];
        for (int i = 0; i < 3; i++) begin
            lat = 0;
            do begin @(posedge clk); #1; lat++; end while (!vld[k] && lat < 400);
            n_chk++;
            if (lat !== nch(k) || syn[k] !== 17'h0 || err[k] !== 1'b0 || dat[k] !== d[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d.%0d]: lat=%0d syn=%h err=%b data=%h want %0d/0/0/%h", k, i, lat, syn[k], err[k], dat[k], nch(k), d[i]);
            end
            if (i == 2) en[k] = 1'b0;
            else begin
                @(posedge clk); #1;
                n_chk++;
                if (vld[k] !== 1'b0 || bsy[k] !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_recapture[%0d.%0d]: valid=%b busy=%b want 0/1", k, i, vld[k], bsy[k]);
                end
                if (i == 0) code[k] = w[2];
            end
        end
    endtask

    task automatic test_busy_ignore(input int k);
        logic [0:144] a, b;
        logic [0:127] got;
        int nv;
        a = enc(rnd_data());
        b = enc(rnd_data()); b[0] = ~b[0];
        got = '0;
        @(negedge clk); en[k] = 1'b1; code[k] = a;
        @(negedge clk); en[k] = 1'b0;
        @(negedge clk); en[k] = 1'b1; code[k] = b;
        n_chk++;
        if (bsy[k] !== 1'b1) begin n_fail++; $display("FAIL busy[%0d]: got %b want 1", k, bsy[k]); end
        @(negedge clk);
        @(negedge clk); en[k] = 1'b0;
        nv = 0;
        repeat (2 * nch(k) + 4) begin
            @(posedge clk); #1;
            if (vld[k]) begin nv++; got = dat[k]; end
        end
        n_chk++;
        if (nv !== 1 || got !== a[0:127]) begin
            n_fail++; $display("FAIL ignore[%0d]: pulses=%0d data=%h want 1/%h", k, nv, got, a[0:127]);
        end
    endtask

    task automatic test_reset_mid(input int k);
        logic [0:144] c;
        int lat, nv;
        c = enc(rnd_data()); c[140] = ~c[140];
        send(k, c, lat);
        @(negedge clk); en[k] = 1'b1; code[k] = enc(rnd_data());
        @(negedge clk); en[k] = 1'b0; rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bsy[k], vld[k], err[k], syn[k], dat[k]} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid[%0d]: busy=%b valid=%b err=%b syn=%h data=%h, want all zero", k, bsy[k], vld[k], err[k], syn[k], dat[k]);
        end
        @(negedge clk); rst_n = 1'b1;
        nv = 0;
        repeat (nch(k) + 5) begin @(posedge clk); #1; if (vld[k]) nv++; end
        n_chk++;
        if (nv !== 0) begin n_fail++; $display("FAIL reset_novalid[%0d]: pulses=%0d want 0", k, nv); end
        c = enc(rnd_data());
        send(k, c, lat);
        n_chk++;
        if (lat !== nch(k) || syn[k] !== 17'h0 || err[k] !== 1'b0 || dat[k] !== c[0:127]) begin
            n_fail++;
            $display("FAIL after_reset[%0d]: lat=%0d syn=%h err=%b data=%h want %0d/0/0/%h", k, lat, syn[k], err[k], dat[k], nch(k), c[0:127]);
        end
    endtask

    initial begin
        en = '{default: 1'b0};
        code = '{default: '0};
        test_reset();
        for (int k = 0; k < 3; k++) begin
            test_zero_word(k);
            test_bit_flip(k);
            test_random(k);
            test_back_to_back(k);
            test_reset_mid(k);
        end
        test_busy_ignore(0);
        test_busy_ignore(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
